// File: rtl/decoder_2x4.sv
// decoder_2x4: 2-to-4 one-hot decoder with a registered status side-stage.
//   d3..d0 : purely combinational decode of {a1,a0}; independent of clk,
//            rst_n and sample_en, so it can be used as a plain gate decoder.
//   dq     : registered one-hot copy, updated only when sample_en is high.
//   sel_chg: one-cycle pulse when a capture differs from the previous one
//            (the first capture after reset always counts as a change).
//   hit_cnt: per-line saturating hit counters, present only when the
//            DECODER_HIT_CNT_EN macro is defined; otherwise tied to zero.
// Reset is synchronous, active low.
module decoder_2x4 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a1,
  input  logic               a0,
  output logic               d3,
  output logic               d2,
  output logic               d1,
  output logic               d0,
  input  logic               sample_en,
  output logic [3:0]         dq,
  output logic               dq_vld,
  output logic               sel_chg,
  output logic [4*CNT_W-1:0] hit_cnt
);

  localparam int NUM_LINES = 4;

  logic [1:0]           sel;
  logic [NUM_LINES-1:0] dec;
  logic [1:0]           prev_sel;

  assign sel = {a1, a0};

  // Gate-level decode; bit i is high iff sel == i.
  assign dec = {a1 & a0, a1 & ~a0, ~a1 & a0, ~a1 & ~a0};

  assign d3 = dec[3];
  assign d2 = dec[2];
  assign d1 = dec[1];
  assign d0 = dec[0];

  // Capture stage: latch the decode, track the previous select, pulse on change.
  // A sample_en that is not a clean 1 falls to the hold branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dq       <= '0;
      dq_vld   <= 1'b0;
      sel_chg  <= 1'b0;
      prev_sel <= 2'b00;
    end else if (sample_en) begin
      dq       <= dec;
      dq_vld   <= 1'b1;
      sel_chg  <= !dq_vld || (sel != prev_sel);
      prev_sel <= sel;
    end else begin
      sel_chg  <= 1'b0;
    end
  end

`ifdef DECODER_HIT_CNT_EN
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    logic [CNT_W-1:0] cnt;

    // Per-line hit counter: bump on a capture of this line, stick at all-ones.
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt <= '0;
      else if (sample_en && dec[i] && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + CNT_W'(1);
    end

    assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_2x4.sv
// Self-checking bench for decoder_2x4. Two instances share the inputs: one at
// the default CNT_W=8 and one at CNT_W=2 so saturation is reached quickly.
// Expected values come from constant tables and a small array-based model.
module tb_decoder_2x4;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;
  logic a1 = 1'b0, a0 = 1'b0;
  logic sample_en;

  logic d3, d2, d1, d0;
  logic [3:0]  dq;
  logic        dq_vld, sel_chg;
  logic [31:0] hit8;

  logic s_d3, s_d2, s_d1, s_d0;
  logic [3:0]  s_dq;
  logic        s_dq_vld, s_sel_chg;
  logic [7:0]  hit2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       cnt8[4];
  int       cnt2[4];
  logic [3:0] dq_m  = 4'b0;
  logic       vld_m = 1'b0;
  logic       chg_m = 1'b0;
  int         prev_m = 0;

  decoder_2x4 #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a0(a0),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .sample_en(sample_en), .dq(dq), .dq_vld(dq_vld), .sel_chg(sel_chg),
    .hit_cnt(hit8)
  );

  decoder_2x4 #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a0(a0),
    .d3(s_d3), .d2(s_d2), .d1(s_d1), .d0(s_d0),
    .sample_en(sample_en), .dq(s_dq), .dq_vld(s_dq_vld), .sel_chg(s_sel_chg),
    .hit_cnt(hit2)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_hit8();
    logic [31:0] r = '0;
`ifdef DECODER_HIT_CNT_EN
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(cnt8[i]);
`endif
    return r;
  endfunction

  function automatic logic [7:0] exp_hit2();
    logic [7:0] r = '0;
`ifdef DECODER_HIT_CNT_EN
    for (int i = 0; i < 4; i++) r[i*2 +: 2] = 2'(cnt2[i]);
`endif
    return r;
  endfunction

  // Counter value as visible on the port given a model count.
  function automatic int vis(input int c);
`ifdef DECODER_HIT_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    int s;
    s = 2 * int'(a1) + int'(a0);
    if (rst_n !== 1'b1) begin
      dq_m = 4'b0; vld_m = 1'b0; chg_m = 1'b0; prev_m = 0;
      for (int i = 0; i < 4; i++) begin cnt8[i] = 0; cnt2[i] = 0; end
    end else if (sample_en === 1'b1) begin
      chg_m  = !vld_m || (s != prev_m);
      dq_m   = 4'b0001 << s;
      vld_m  = 1'b1;
      prev_m = s;
      if (cnt8[s] < 255) cnt8[s]++;
      if (cnt2[s] < 3)   cnt2[s]++;
    end else begin
      chg_m = 1'b0;
    end
  endtask

  task automatic chk_comb(input string nm);
    logic [3:0] exp;
    exp = 4'b0001 << {a1, a0};
    chk(nm, {d3, d2, d1, d0}, exp);
    chk({nm, "_sat"}, {s_d3, s_d2, s_d1, s_d0}, exp);
  endtask

  task automatic chk_regs();
    chk("dq", dq, dq_m);
    chk("dq_vld", dq_vld, vld_m);
    chk("sel_chg", sel_chg, chg_m);
    chk("hit8", hit8, exp_hit8());
    chk("dq_s", s_dq, dq_m);
    chk("dq_vld_s", s_dq_vld, vld_m);
    chk("sel_chg_s", s_sel_chg, chg_m);
    chk("hit2", hit2, exp_hit2());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_regs();
  endtask

  typedef struct { logic [1:0] sel; logic [3:0] d; } comb_t;
  typedef struct { logic [1:0] sel; logic [3:0] dq; logic chg; } cap_t;

  comb_t comb_tab[4];
  cap_t  cap_tab[3];

  initial begin
    for (int i = 0; i < 4; i++) begin cnt8[i] = 0; cnt2[i] = 0; end
    comb_tab[0] = '{2'b00, 4'b0001};
    comb_tab[1] = '{2'b01, 4'b0010};
    comb_tab[2] = '{2'b10, 4'b0100};
    comb_tab[3] = '{2'b11, 4'b1000};
    cap_tab[0]  = '{2'b01, 4'b0010, 1'b1};
    cap_tab[1]  = '{2'b01, 4'b0010, 1'b0};
    cap_tab[2]  = '{2'b10, 4'b0100, 1'b1};

    // combinational sweep: clock idle, sample_en never driven
    for (int i = 0; i < 4; i++) begin
      {a1, a0} = comb_tab[i].sel;
      #10;
      chk("comb_sweep", {d3, d2, d1, d0}, comb_tab[i].d);
    end

    // reset for two edges with sample_en=1, select=11
    clk_run = 1'b1;
    rst_n = 1'b0; sample_en = 1'b1; {a1, a0} = 2'b11;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_dq", dq, 4'b0000);
      chk("rst_vld", dq_vld, 1'b0);
      chk("rst_chg", sel_chg, 1'b0);
      chk("rst_hit", hit8, 32'h0);
      chk("rst_d3", d3, 1'b1);
    end

    // capture sequence 01,01,10
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {a1, a0} = cap_tab[i].sel;
      tick();
      chk("cap_dq", dq, cap_tab[i].dq);
      chk("cap_chg", sel_chg, cap_tab[i].chg);
    end
    chk("cap_hit1", hit8[15:8], 8'(vis(2)));
    chk("cap_hit2", hit8[23:16], 8'(vis(1)));

    // hold: capture 11, then three edges with sample_en low
    {a1, a0} = 2'b11;
    tick();
    sample_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      {a1, a0} = 2'(k);
      #1;
      chk_comb("hold_live");
      tick();
      chk("hold_dq", dq, 4'b1000);
      chk("hold_chg", sel_chg, 1'b0);
      chk("hold_hit3", hit8[31:24], 8'(vis(1)));
    end

    // saturation on the CNT_W=2 instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; sample_en = 1'b1; {a1, a0} = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_line0", hit2[1:0], 2'(vis((k + 1 > 3) ? 3 : k + 1)));
    end

    // mid-operation reset
    rst_n = 1'b0;
    tick();
    chk("mid_dq", dq, 4'b0000);
    chk("mid_vld", dq_vld, 1'b0);
    chk("mid_chg", sel_chg, 1'b0);
    chk("mid_hit", hit8, 32'h0);
    chk("mid_hit_s", hit2, 8'h0);
    rst_n = 1'b1; {a1, a0} = 2'b10;
    tick();
    chk("post_chg", sel_chg, 1'b1);
    chk("post_hit2", hit8[23:16], 8'(vis(1)));

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 24) != 0);
      sample_en = 1'($urandom_range(0, 3) != 0);
      {a1, a0}  = 2'($urandom_range(0, 3));
      #1;
      chk_comb("rand_comb");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
